johnson_seq_ctrl: RTL and testbench

- Run controller for a WIDTH-bit Johnson counter.
- Accepts a start request with a loop count and steps the Johnson state through full 2*WIDTH-phase rotations, with hold and stop.
- Decodes the state into one-hot phase enables and signals completion with a done pulse.
- Sits between a requesting master and downstream phase-driven datapaths: multiphase strobes, sequenced enables.

---
 rtl/johnson_seq_ctrl.sv | 162 ++++++++++++++++
 tb/tb_johnson_seq_ctrl.sv | 199 +++++++++++++++++++
 2 files changed

// File: rtl/johnson_seq_ctrl.sv
// johnson_seq_ctrl
//   Run controller for a WIDTH-bit Johnson counter. A start request latches a
//   loop count and the counter then steps through full 2*WIDTH-phase
//   rotations. The run can be frozen with hold and aborted with stop. The
//   current state is decoded into one-hot phase enables, and the end of a run
//   is signalled with a single-cycle done pulse.
//
//   Build option: define JOHNSON_SELF_CORRECT_EN to force an illegal counter
//   code back to all-zero while running. That restarts the current rotation
//   and raises err for one cycle. Without the macro, illegal codes shift
//   normally and err stays 0.
//
// Parameters
//   WIDTH  Johnson register length (sequence has 2*WIDTH states)
//   LOOPW  width of loop-count request and internal loop counter
//
// Ports
//   clk    in   clock, rising edge
//   rst_n  in   asynchronous active-low reset
//   start  in   run request, sampled only in IDLE
//   loops  in   rotations to run; 0 = free-run until stop
//   hold   in   freeze counter and loop count while high
//   stop   in   abort current run
//   busy   out  high while in RUN
//   done   out  single-cycle completion pulse
//   wrap   out  counter steps from last state back to all-zero this cycle
//   o_cnt  out  current Johnson state
//   phase  out  one-hot phase decode, zero when not busy
//   err    out  illegal-code pulse (self-correct build only)
module johnson_seq_ctrl #(
  parameter int WIDTH = 4,
  parameter int LOOPW = 8
) (
  input  logic                 clk,
  input  logic                 rst_n,
  input  logic                 start,
  input  logic [LOOPW-1:0]     loops,
  input  logic                 hold,
  input  logic                 stop,
  output logic                 busy,
  output logic                 done,
  output logic                 wrap,
  output logic [WIDTH-1:0]     o_cnt,
  output logic [2*WIDTH-1:0]   phase,
  output logic                 err
);

  localparam int NPH = 2 * WIDTH;
  localparam logic [WIDTH-1:0] ONES     = '1;
  localparam logic [LOOPW-1:0] LOOP_ONE = LOOPW'(1);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RUN  = 2'd1,
    DONE = 2'd2
  } state_t;

  state_t           state_reg, state_next;
  logic [WIDTH-1:0] cnt_reg, cnt_next;
  logic [LOOPW-1:0] loop_cnt_reg, loop_cnt_next;
  logic [LOOPW-1:0] loops_q_reg, loops_q_next;

  logic [NPH-1:0]   code_hit;
  logic [WIDTH-1:0] cnt_step;
  logic             at_last;
  logic             last_loop;
  logic             correct_illegal;

  // Match the counter against every legal Johnson code.
  // Phases 0..WIDTH-1 fill with ones from the MSB: 0000, 1000, 1100, ...
  // Phases WIDTH..2*WIDTH-1 drain ones from the MSB side: 1111, 0111, ...
  // For an illegal code no bit matches, so the phase decode is all zero.
  generate
    for (genvar gi = 0; gi < NPH; gi++) begin : g_code
      if (gi < WIDTH) begin : g_fill
        assign code_hit[gi] = (cnt_reg == ~(ONES >> gi));
      end else begin : g_drain
        assign code_hit[gi] = (cnt_reg == (ONES >> (gi - WIDTH)));
      end
    end
  endgenerate

`ifdef JOHNSON_SELF_CORRECT_EN
  assign correct_illegal = ~(|code_hit);
`else
  assign correct_illegal = 1'b0;
`endif

  assign cnt_step  = {~cnt_reg[0], cnt_reg[WIDTH-1:1]};
  assign at_last   = code_hit[NPH-1];
  assign last_loop = (loops_q_reg != '0) && (loop_cnt_reg == loops_q_reg - LOOP_ONE);

  assign busy  = (state_reg == RUN);
  assign done  = (state_reg == DONE);
  assign wrap  = busy & ~hold & ~stop & at_last;
  assign o_cnt = cnt_reg;
  assign phase = busy ? code_hit : '0;
  assign err   = busy & correct_illegal;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_reg    <= IDLE;
      cnt_reg      <= '0;
      loop_cnt_reg <= '0;
      loops_q_reg  <= '0;
    end else begin
      state_reg    <= state_next;
      cnt_reg      <= cnt_next;
      loop_cnt_reg <= loop_cnt_next;
      loops_q_reg  <= loops_q_next;
    end
  end

  always_comb begin
    state_next    = state_reg;
    cnt_next      = cnt_reg;
    loop_cnt_next = loop_cnt_reg;
    loops_q_next  = loops_q_reg;

    case (state_reg)
      IDLE: begin
        if (start) begin
          loops_q_next  = loops;
          cnt_next      = '0;
          loop_cnt_next = '0;
          state_next    = RUN;
        end
      end

      RUN: begin
        // stop wins over hold and over a wrap in the same cycle.
        if (stop) begin
          state_next = DONE;
          cnt_next   = '0;
        end else if (correct_illegal) begin
          // Restart the current rotation; the loop count is untouched.
          cnt_next = '0;
        end else if (!hold) begin
          if (at_last && last_loop) begin
            state_next = DONE;
            cnt_next   = '0;
          end else begin
            // In free-run mode (loops_q == 0) the loop counter wraps silently.
            if (at_last) begin
              loop_cnt_next = loop_cnt_reg + LOOP_ONE;
            end
            cnt_next = cnt_step;
          end
        end
      end

      DONE: begin
        state_next = IDLE;
      end

      default: begin
        state_next = IDLE;
      end
    endcase
  end

endmodule

// File: tb/tb_johnson_seq_ctrl.sv
// tb_johnson_seq_ctrl
//   Self-checking bench for johnson_seq_ctrl. A behavioural model tracks the
//   run as (mode, phase index, completed rotations, requested loops). The
//   expected Johnson code is derived arithmetically from the phase index.
//   The bench runs the directed scenarios first and then randomized
//   start/loops/hold/stop/reset traffic.
module tb_johnson_seq_ctrl;

  localparam int W  = 4;
  localparam int LW = 8;
  localparam int NP = 2 * W;

  logic          clk = 1'b0;
  logic          rst_n;
  logic          start;
  logic [LW-1:0] loops;
  logic          hold;
  logic          stop;
  logic          busy;
  logic          done;
  logic          wrap;
  logic [W-1:0]  o_cnt;
  logic [NP-1:0] phase;
  logic          err;

  int n_checks = 0;
  int n_pass   = 0;

  // Model: mode 0 = idle, 1 = running, 2 = done cycle.
  int m_mode, m_k, m_r, m_l;
  int busy_seen, done_seen, wrap_seen;

  johnson_seq_ctrl #(.WIDTH(W), .LOOPW(LW)) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .start (start),
    .loops (loops),
    .hold  (hold),
    .stop  (stop),
    .busy  (busy),
    .done  (done),
    .wrap  (wrap),
    .o_cnt (o_cnt),
    .phase (phase),
    .err   (err)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got === exp) n_pass++;
    else $display("FAIL %s: got %0h expected %0h at %0t", tag, got, exp, $time);
  endtask

  // Phase k of a Johnson ring: k ones shifted in from the top, then drained.
  function automatic logic [W-1:0] code_of(input int k);
    int full;
    full = (1 << W) - 1;
    if (k <= W) return W'(full ^ ((1 << (W - k)) - 1));
    else        return W'((1 << (NP - k)) - 1);
  endfunction

  task automatic model_reset();
    m_mode = 0; m_k = 0; m_r = 0; m_l = 0;
  endtask

  task automatic model_step(input logic s, input logic [LW-1:0] l, input logic h, input logic sp);
    case (m_mode)
      0: if (s) begin m_mode = 1; m_k = 0; m_r = 0; m_l = int'(l); end
      1: begin
        if (sp) begin
          m_mode = 2; m_k = 0;
        end else if (!h) begin
          if (m_k == NP - 1) begin
            m_k = 0;
            if (m_l != 0 && m_r == m_l - 1) m_mode = 2;
            else m_r = (m_r + 1) % (1 << LW);
          end else begin
            m_k = m_k + 1;
          end
        end
      end
      default: m_mode = 0;
    endcase
  endtask

  task automatic compare_outputs();
    logic e_busy;
    e_busy = (m_mode == 1);
    check("busy",  busy,  e_busy);
    check("done",  done,  m_mode == 2);
    check("o_cnt", o_cnt, code_of(m_k));
    check("phase", phase, e_busy ? (32'd1 << m_k) : 32'd0);
    check("wrap",  wrap,  e_busy && !hold && !stop && (m_k == NP - 1));
    check("err",   err,   1'b0);
  endtask

  task automatic step(input logic s, input logic [LW-1:0] l, input logic h, input logic sp);
    @(negedge clk);
    start = s; loops = l; hold = h; stop = sp;
    #1;
    compare_outputs();
    busy_seen += int'(busy);
    done_seen += int'(done);
    wrap_seen += int'(wrap);
    @(posedge clk);
    model_step(s, l, h, sp);
  endtask

  task automatic async_reset();
    @(negedge clk);
    start = 1'b0; loops = '0; hold = 1'b0; stop = 1'b0;
    #2;
    rst_n = 1'b0;
    #1;
    model_reset();
    compare_outputs();
    @(negedge clk);
    rst_n = 1'b1;
  endtask

  task automatic clear_counts();
    busy_seen = 0; done_seen = 0; wrap_seen = 0;
  endtask

  initial begin
    rst_n = 1'b0; start = 1'b0; loops = '0; hold = 1'b0; stop = 1'b0;
    model_reset();
    #3;
    compare_outputs();
    @(negedge clk);
    rst_n = 1'b1;

    // Two full rotations, no hold or stop.
    clear_counts();
    step(1'b1, 8'd2, 1'b0, 1'b0);
    repeat (18) step(1'b0, 8'd0, 1'b0, 1'b0);
    check("s1_busy_len", busy_seen, 16);
    check("s1_wraps",    wrap_seen, 2);
    check("s1_dones",    done_seen, 1);

    // Single rotation with a 3-cycle hold at 1110.
    clear_counts();
    step(1'b1, 8'd1, 1'b0, 1'b0);
    repeat (3) step(1'b0, 8'd0, 1'b0, 1'b0);
    repeat (3) step(1'b0, 8'd0, 1'b1, 1'b0);
    repeat (10) step(1'b0, 8'd0, 1'b0, 1'b0);
    check("s2_busy_len", busy_seen, 11);
    check("s2_dones",    done_seen, 1);

    // Free-run, stop during the 21st busy cycle (o_cnt = 1111).
    clear_counts();
    step(1'b1, 8'd0, 1'b0, 1'b0);
    repeat (20) step(1'b0, 8'd0, 1'b0, 1'b0);
    step(1'b0, 8'd0, 1'b0, 1'b1);
    repeat (6) step(1'b0, 8'd0, 1'b0, 1'b0);
    check("s3_busy_len", busy_seen, 21);
    check("s3_wraps",    wrap_seen, 2);
    check("s3_dones",    done_seen, 1);

    // stop + hold at the last state; start in RUN ignored.
    clear_counts();
    step(1'b1, 8'd1, 1'b0, 1'b0);
    step(1'b0, 8'd0, 1'b0, 1'b0);
    repeat (6) step(1'b1, 8'd3, 1'b0, 1'b0);
    step(1'b0, 8'd0, 1'b1, 1'b1);
    repeat (3) step(1'b0, 8'd0, 1'b0, 1'b0);
    check("s4_busy_len", busy_seen, 8);
    check("s4_wraps",    wrap_seen, 0);
    check("s4_dones",    done_seen, 1);

    // Asynchronous reset at o_cnt = 1100; no done pulse afterwards.
    clear_counts();
    step(1'b1, 8'd3, 1'b0, 1'b0);
    repeat (2) step(1'b0, 8'd0, 1'b0, 1'b0);
    async_reset();
    repeat (3) step(1'b0, 8'd0, 1'b0, 1'b0);
    check("s5_dones", done_seen, 0);
    step(1'b1, 8'd1, 1'b0, 1'b0);
    repeat (10) step(1'b0, 8'd0, 1'b0, 1'b0);

    // Randomized traffic.
    repeat (3000) begin
      if ($urandom_range(0, 399) == 0) begin
        async_reset();
      end else begin
        step($urandom_range(0, 3) == 0,
             LW'($urandom_range(0, 3)),
             $urandom_range(0, 7) == 0,
             $urandom_range(0, 39) == 0);
      end
    end

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
